// File: rtl/multi_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : multi_edge_detect
// Brief    : Multi-channel debounced edge detector with Mealy/Moore ticks,
//            run-time polarity select and a saturating event counter.
// Revision : 1.0 - initial release
// ============================================================================
module multi_edge_detect #(
  parameter int CH  = 4,
  parameter int DEB = 4,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CH-1:0] level,
  input  logic [1:0]    mode,
  input  logic          clr,
  output logic [CH-1:0] tick_mealy,
  output logic [CH-1:0] tick_moore,
  output logic [CH-1:0] level_db,
  output logic [CW-1:0] edge_count
);

  localparam int                  c_CNT_W    = $clog2(DEB + 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(DEB - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [CW-1:0]       c_CNT_MAX  = '1;

  localparam logic [1:0] c_LOW       = 2'd0;
  localparam logic [1:0] c_WAIT_HIGH = 2'd1;
  localparam logic [1:0] c_HIGH      = 2'd2;
  localparam logic [1:0] c_WAIT_LOW  = 2'd3;

  logic w_rise_q;
  logic w_fall_q;

  assign w_rise_q = (mode == 2'b00) || (mode == 2'b10);
  assign w_fall_q = (mode == 2'b01) || (mode == 2'b10);

  genvar g;
  generate
    for (g = 0; g < CH; g++) begin : g_ch
      logic [1:0]         r_state;
      logic [1:0]         w_state_nxt;
      logic [c_CNT_W-1:0] r_cnt;
      logic [c_CNT_W-1:0] w_cnt_nxt;
      logic               w_acc_rise;
      logic               w_acc_fall;
      logic               w_tick;
      logic               w_db;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_state <= c_LOW;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_cnt   <= w_cnt_nxt;
        end
      end

      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_rise  = 1'b0;
        w_acc_fall  = 1'b0;
        case (r_state)
          c_LOW: begin
            w_cnt_nxt = '0;
            if (level[g]) begin
              if (DEB == 1) begin
                w_state_nxt = c_HIGH;
                w_acc_rise  = 1'b1;
              end else begin
                w_state_nxt = c_WAIT_HIGH;
                w_cnt_nxt   = c_CNT_ONE;
              end
            end
          end
          c_WAIT_HIGH: begin
            if (!level[g]) begin
              w_state_nxt = c_LOW;
              w_cnt_nxt   = '0;
            end else if (r_cnt == c_CNT_LAST) begin
              w_state_nxt = c_HIGH;
              w_cnt_nxt   = '0;
              w_acc_rise  = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
          end
          c_HIGH: begin
            w_cnt_nxt = '0;
            if (!level[g]) begin
              if (DEB == 1) begin
                w_state_nxt = c_LOW;
                w_acc_fall  = 1'b1;
              end else begin
                w_state_nxt = c_WAIT_LOW;
                w_cnt_nxt   = c_CNT_ONE;
              end
            end
          end
          c_WAIT_LOW: begin
            if (level[g]) begin
              w_state_nxt = c_HIGH;
              w_cnt_nxt   = '0;
            end else if (r_cnt == c_CNT_LAST) begin
              w_state_nxt = c_LOW;
              w_cnt_nxt   = '0;
              w_acc_fall  = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
          end
          default: begin
            w_state_nxt = c_LOW;
            w_cnt_nxt   = '0;
          end
        endcase
      end

      // Gate with reset so a DEB=1 channel cannot tick while held in reset.
      always_comb begin
        w_tick = reset_n & ((w_acc_rise & w_rise_q) | (w_acc_fall & w_fall_q));
        w_db   = (r_state == c_HIGH) || (r_state == c_WAIT_LOW);
      end

      assign tick_mealy[g] = w_tick;
      assign level_db[g]   = w_db;
    end
  endgenerate

  logic [CH-1:0] r_tick_moore;
  logic [CW-1:0] r_edge_count;
  logic [CW-1:0] w_pop;
  logic [CW:0]   w_sum;

  // Extra sum bit flags overflow; CW is wide enough to hold CH.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < CH; i++) begin
      w_pop = w_pop + CW'(r_tick_moore[i]);
    end
    w_sum = {1'b0, r_edge_count} + {1'b0, w_pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_moore <= '0;
      r_edge_count <= '0;
    end else begin
      r_tick_moore <= tick_mealy;
      if (clr) begin
        r_edge_count <= '0;
      end else if (w_sum[CW]) begin
        r_edge_count <= c_CNT_MAX;
      end else begin
        r_edge_count <= w_sum[CW-1:0];
      end
    end
  end

  assign tick_moore = r_tick_moore;
  assign edge_count = r_edge_count;

endmodule
`default_nettype wire

// File: tb/tb_multi_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_edge_detect
// Brief    : Directed self-checking bench for multi_edge_detect.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_edge_detect;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic [3:0] level_a = '0, mealy_a, moore_a, db_a;
  logic [1:0] mode_a = '0;
  logic       clr_a = 1'b0;
  logic [7:0] count_a;

  logic [3:0] level_s = '0, mealy_s, moore_s, db_s;
  logic [1:0] mode_s = '0;
  logic       clr_s = 1'b0;
  logic [2:0] count_s;

  logic [3:0] level_d = '0, mealy_d, moore_d, db_d;
  logic [1:0] mode_d = '0;
  logic       clr_d = 1'b0;
  logic [7:0] count_d;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multi_edge_detect #(.CH(4), .DEB(4), .CW(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .level(level_a), .mode(mode_a), .clr(clr_a),
    .tick_mealy(mealy_a), .tick_moore(moore_a), .level_db(db_a), .edge_count(count_a)
  );

  multi_edge_detect #(.CH(4), .DEB(4), .CW(3)) u_sat (
    .clk(clk), .reset_n(reset_n), .level(level_s), .mode(mode_s), .clr(clr_s),
    .tick_mealy(mealy_s), .tick_moore(moore_s), .level_db(db_s), .edge_count(count_s)
  );

  multi_edge_detect #(.CH(4), .DEB(1), .CW(8)) u_deb1 (
    .clk(clk), .reset_n(reset_n), .level(level_d), .mode(mode_d), .clr(clr_d),
    .tick_mealy(mealy_d), .tick_moore(moore_d), .level_db(db_d), .edge_count(count_d)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    level_a = '0; level_s = '0; level_d = '0;
    mode_a  = '0; mode_s  = '0; mode_d  = '0;
    clr_a   = 0;  clr_s   = 0;  clr_d   = 0;
    reset_n = 0;
    next_cycle();
    next_cycle();
    reset_n = 1;
  endtask

  task automatic test_reset;
    apply_reset();
    #2;
    checks++; if (mealy_a !== 4'h0) begin errors++; $display("FAIL reset_mealy got=%b exp=0000", mealy_a); end
    checks++; if (moore_a !== 4'h0) begin errors++; $display("FAIL reset_moore got=%b exp=0000", moore_a); end
    checks++; if (db_a !== 4'h0) begin errors++; $display("FAIL reset_level_db got=%b exp=0000", db_a); end
    checks++; if (count_a !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_a); end
    checks++; if (count_s !== 3'd0) begin errors++; $display("FAIL reset_count_sat got=%0d exp=0", count_s); end
  endtask

  task automatic test_clean_rise;
    logic [3:0] em, eo, ed;
    logic [7:0] ec;
    apply_reset();
    next_cycle();
    level_a[0] = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      em = (c == 4) ? 4'b0001 : 4'b0000;
      eo = (c == 5) ? 4'b0001 : 4'b0000;
      ed = (c >= 5) ? 4'b0001 : 4'b0000;
      ec = (c >= 6) ? 8'd1 : 8'd0;
      #2;
      checks++; if (mealy_a !== em) begin errors++; $display("FAIL rise_mealy c=%0d got=%b exp=%b", c, mealy_a, em); end
      checks++; if (moore_a !== eo) begin errors++; $display("FAIL rise_moore c=%0d got=%b exp=%b", c, moore_a, eo); end
      checks++; if (db_a !== ed) begin errors++; $display("FAIL rise_level_db c=%0d got=%b exp=%b", c, db_a, ed); end
      checks++; if (count_a !== ec) begin errors++; $display("FAIL rise_count c=%0d got=%0d exp=%0d", c, count_a, ec); end
      next_cycle();
    end
  endtask

  task automatic test_glitch;
    logic [3:0] em, eo, ed;
    apply_reset();
    next_cycle();
    for (int c = 1; c <= 10; c++) begin
      level_a[1] = (c <= 3);
      #2;
      checks++; if ((mealy_a | moore_a | db_a) !== 4'h0) begin
        errors++; $display("FAIL glitch_quiet c=%0d got=%b/%b/%b exp=0000", c, mealy_a, moore_a, db_a);
      end
      next_cycle();
    end
    checks++; if (count_a !== 8'd0) begin errors++; $display("FAIL glitch_count got=%0d exp=0", count_a); end
    for (int c = 1; c <= 12; c++) begin
      level_a[1] = (c <= 4);
      em = (c == 4) ? 4'b0010 : 4'b0000;
      eo = (c == 5) ? 4'b0010 : 4'b0000;
      ed = (c >= 5 && c <= 8) ? 4'b0010 : 4'b0000;
      #2;
      checks++; if (mealy_a !== em) begin errors++; $display("FAIL pulse4_mealy c=%0d got=%b exp=%b", c, mealy_a, em); end
      checks++; if (moore_a !== eo) begin errors++; $display("FAIL pulse4_moore c=%0d got=%b exp=%b", c, moore_a, eo); end
      checks++; if (db_a !== ed) begin errors++; $display("FAIL pulse4_level_db c=%0d got=%b exp=%b", c, db_a, ed); end
      next_cycle();
    end
    checks++; if (count_a !== 8'd1) begin errors++; $display("FAIL pulse4_count got=%0d exp=1", count_a); end
  endtask

  task automatic test_modes;
    int n_tick, n_moore, n_db, first, et, ef;
    for (int m = 0; m < 4; m++) begin
      case (m)
        0: begin et = 1; ef = 4;  end
        1: begin et = 1; ef = 14; end
        2: begin et = 2; ef = 4;  end
        default: begin et = 0; ef = 0; end
      endcase
      apply_reset();
      mode_a = 2'(m);
      n_tick = 0; n_moore = 0; n_db = 0; first = 0;
      next_cycle();
      for (int c = 1; c <= 20; c++) begin
        level_a[2] = (c <= 10);
        #2;
        if (mealy_a[2]) begin
          n_tick++;
          if (first == 0) first = c;
        end
        if (moore_a[2]) n_moore++;
        if (db_a[2]) n_db++;
        next_cycle();
      end
      checks++; if (n_tick !== et) begin errors++; $display("FAIL mode%0d_mealy_ticks got=%0d exp=%0d", m, n_tick, et); end
      checks++; if (n_moore !== et) begin errors++; $display("FAIL mode%0d_moore_ticks got=%0d exp=%0d", m, n_moore, et); end
      checks++; if (first !== ef) begin errors++; $display("FAIL mode%0d_first_tick_cycle got=%0d exp=%0d", m, first, ef); end
      checks++; if (n_db !== 10) begin errors++; $display("FAIL mode%0d_level_db_cycles got=%0d exp=10", m, n_db); end
      checks++; if (count_a !== 8'(et)) begin errors++; $display("FAIL mode%0d_count got=%0d exp=%0d", m, count_a, et); end
    end
  endtask

  task automatic test_simultaneous_saturation;
    logic [2:0] ec;
    logic [3:0] em;
    apply_reset();
    mode_s = 2'b10;
    next_cycle();
    for (int c = 1; c <= 19; c++) begin
      level_s = (c <= 6 || c >= 13) ? 4'hF : 4'h0;
      clr_s   = (c == 17);
      em = (c == 4 || c == 10 || c == 16) ? 4'hF : 4'h0;
      ec = (c <= 5) ? 3'd0 : (c <= 11) ? 3'd4 : (c <= 17) ? 3'd7 : 3'd0;
      #2;
      checks++; if (mealy_s !== em) begin errors++; $display("FAIL sat_mealy c=%0d got=%b exp=%b", c, mealy_s, em); end
      checks++; if (count_s !== ec) begin errors++; $display("FAIL sat_count c=%0d got=%0d exp=%0d", c, count_s, ec); end
      next_cycle();
    end
    clr_s = 0;
  endtask

  task automatic test_reset_mid_debounce;
    logic [3:0] em, eo;
    apply_reset();
    next_cycle();
    for (int c = 1; c <= 8; c++) begin
      level_a = (c >= 7) ? 4'b1001 : 4'b1000;
      #2;
      next_cycle();
    end
    #1;
    checks++; if (db_a !== 4'b1000) begin errors++; $display("FAIL pre_reset_level_db got=%b exp=1000", db_a); end
    checks++; if (count_a !== 8'd1) begin errors++; $display("FAIL pre_reset_count got=%0d exp=1", count_a); end
    reset_n = 0;
    #1;
    checks++; if ((mealy_a | moore_a | db_a) !== 4'h0) begin
      errors++; $display("FAIL mid_reset_outputs got=%b/%b/%b exp=0000", mealy_a, moore_a, db_a);
    end
    checks++; if (count_a !== 8'd0) begin errors++; $display("FAIL mid_reset_count got=%0d exp=0", count_a); end
    next_cycle();
    next_cycle();
    checks++; if ((mealy_a | moore_a | db_a) !== 4'h0) begin
      errors++; $display("FAIL held_reset_outputs got=%b/%b/%b exp=0000", mealy_a, moore_a, db_a);
    end
    reset_n = 1;
    for (int r = 1; r <= 5; r++) begin
      em = (r == 4) ? 4'b1001 : 4'b0000;
      eo = (r == 5) ? 4'b1001 : 4'b0000;
      #2;
      checks++; if (mealy_a !== em) begin errors++; $display("FAIL post_reset_mealy r=%0d got=%b exp=%b", r, mealy_a, em); end
      checks++; if (moore_a !== eo) begin errors++; $display("FAIL post_reset_moore r=%0d got=%b exp=%b", r, moore_a, eo); end
      next_cycle();
    end
    #1;
    checks++; if (count_a !== 8'd2) begin errors++; $display("FAIL post_reset_count got=%0d exp=2", count_a); end
  endtask

  task automatic test_deb1;
    apply_reset();
    level_d = 4'hF;
    reset_n = 0;
    #2;
    checks++; if (mealy_d !== 4'h0) begin errors++; $display("FAIL deb1_reset_mealy got=%b exp=0000", mealy_d); end
    level_d = 4'h0;
    next_cycle();
    reset_n = 1;
    mode_d  = 2'b10;
    next_cycle();
    level_d[0] = 1'b1;
    #2;
    checks++; if (mealy_d !== 4'b0001) begin errors++; $display("FAIL deb1_rise_mealy got=%b exp=0001", mealy_d); end
    checks++; if (moore_d !== 4'b0000) begin errors++; $display("FAIL deb1_rise_moore_early got=%b exp=0000", moore_d); end
    next_cycle();
    #2;
    checks++; if (mealy_d !== 4'b0000) begin errors++; $display("FAIL deb1_hold_mealy got=%b exp=0000", mealy_d); end
    checks++; if (moore_d !== 4'b0001) begin errors++; $display("FAIL deb1_rise_moore got=%b exp=0001", moore_d); end
    checks++; if (db_d !== 4'b0001) begin errors++; $display("FAIL deb1_level_db_high got=%b exp=0001", db_d); end
    next_cycle();
    level_d[0] = 1'b0;
    #2;
    checks++; if (mealy_d !== 4'b0001) begin errors++; $display("FAIL deb1_fall_mealy got=%b exp=0001", mealy_d); end
    checks++; if (count_d !== 8'd1) begin errors++; $display("FAIL deb1_count1 got=%0d exp=1", count_d); end
    next_cycle();
    #2;
    checks++; if (moore_d !== 4'b0001) begin errors++; $display("FAIL deb1_fall_moore got=%b exp=0001", moore_d); end
    checks++; if (db_d !== 4'b0000) begin errors++; $display("FAIL deb1_level_db_low got=%b exp=0000", db_d); end
    next_cycle();
    #2;
    checks++; if (count_d !== 8'd2) begin errors++; $display("FAIL deb1_count2 got=%0d exp=2", count_d); end
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_glitch();
    test_modes();
    test_simultaneous_saturation();
    test_reset_mid_debounce();
    test_deb1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_edge_detect.md
# multi_edge_detect

Parametrised multi-channel edge detector with per-channel debounce. It replaces the single-channel Moore/Mealy detectors as the standard conditioning block between raw level inputs (buttons, strobes, status lines) and downstream control logic. Each channel has both a combinational (Mealy) and a registered (Moore) one-cycle tick. Edge polarity is selectable at run time, and a saturating counter accumulates accepted events.

## Interface
- `CH`, 4: number of independent channels, ≥1.
- `DEB`, 4: consecutive samples of a new level required to accept an edge, ≥1. `DEB=1` means no debounce.
- `CW`, 8: width of `edge_count`, ≥ `$clog2(CH+1)`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `level` in `CH`: raw input levels, assumed synchronous to `clk`.
- `mode` in 2: qualification, shared by all channels.
  - 00: rising edges only.
  - 01: falling edges only.
  - 10: both edges.
  - 11: no ticks produced; channels are still tracked.
- `clr` in 1: synchronous clear of `edge_count`.
- `tick_mealy` out `CH`: combinational tick, high in the cycle an edge is accepted.
- `tick_moore` out `CH`: registered tick, high for the one cycle after acceptance.
- `level_db` out `CH`: debounced level, 1 in states `HIGH` and `WAIT_LOW`.
- `edge_count` out `CW`: saturating count of `tick_moore` pulses.

## Operation
Each channel has a 4-state FSM (`LOW`, `WAIT_HIGH`, `HIGH`, `WAIT_LOW`) and a debounce counter of width `$clog2(DEB+1)`.

- `LOW`, `level=1`:
  - `DEB=1`: go to `HIGH` and accept a rising edge.
  - Otherwise: go to `WAIT_HIGH` with `cnt=1`.
- `WAIT_HIGH`:
  - `level=0`: go to `LOW`, `cnt=0`, no tick (glitch rejected).
  - `level=1` and `cnt==DEB-1`: go to `HIGH`, `cnt=0`, accept a rising edge.
  - Otherwise: `cnt++`.
- `HIGH`, `WAIT_LOW`: mirror image of the above, with inverted level, accepting a falling edge.
- Any unused encoding: next state `LOW`, `cnt=0`.

Tick generation:
- An accepted edge is *qualified* when `mode` selects its polarity.
- `tick_mealy[i]` = accept & qualified, evaluated in the same cycle. `mode` changes take effect immediately.
- `tick_moore[i]` is `tick_mealy[i]` registered.

Edge counter:
- Each cycle, `edge_count` adds popcount(`tick_moore`) and saturates at 2^CW−1. It never wraps.
- `clr=1` sets `edge_count` to 0 and takes priority over increments arriving in the same cycle.

Reset (`reset_n=0`, asynchronous, any time including mid-debounce):
- All channels go to `LOW` with `cnt=0`.
- `tick_moore=0`, `edge_count=0`.
- `tick_mealy=0` while reset is held.
- A level already high when reset releases is treated as a rising edge after `DEB` samples.

## Timing
- Mealy latency: the tick is asserted during the `DEB`-th consecutive cycle sampling the new level, before the clock edge that moves the FSM to `HIGH`/`LOW`.
- Moore latency: one cycle after the Mealy tick. Width is exactly one cycle per accepted edge.
- `level_db` changes on the same clock edge that ends the Mealy tick.
- `edge_count` updates on the edge after the Moore tick cycle, i.e. DEB+1 edges after `level` first changes.
- Minimum edge spacing is `DEB` cycles. Pulses shorter than `DEB` cycles produce no tick and no `level_db` change.
- Channels are fully independent. Simultaneous ticks on all channels add `CH` to the count in one cycle.

## Test plan
1. **Reset, then a clean rise.** Apply reset, then drive `level[0]` high with `DEB=4`, `mode=00`.
   - `tick_mealy[0]` is high in the 4th high cycle.
   - `tick_moore[0]` is high in the 5th cycle.
   - `level_db[0]` goes to 1 and `edge_count` goes to 1.
2. **Glitch rejection.** With `DEB=4`, drive `level[1]` high for 3 cycles, then low.
   - No tick, `level_db[1]` stays 0, `edge_count` stays 0.
   - A 4-cycle pulse produces exactly one rising tick.
3. **Modes.** Apply a 10-cycle high pulse on `ch2` under each mode.
   - `mode=01`: one tick, on the fall only.
   - `mode=10`: two ticks.
   - `mode=11`: zero ticks, but `level_db` still toggles.
4. **Simultaneous channels and saturation.** With `CW=3`, drive all 4 channels high together.
   - `edge_count` goes 0→4 in one step.
   - A second both-edge pass clamps the count at 7.
   - `clr` asserted in a tick cycle gives `edge_count=0`.
5. **Reset mid-debounce.** Drop `reset_n` when `cnt=2` in `WAIT_HIGH`.
   - All outputs go to 0 immediately.
   - After release, `DEB` full cycles of high are required before a tick.
6. **`DEB=1`.**
   - `tick_mealy` is high in the same cycle `level` rises.
   - `tick_moore` is high one cycle later.
